// File: rtl/td4_program_memory.sv
// Program memory for the 4-bit CPU: asynchronous fetch read, streamed program load, zero-fill,
// and CPU reset hold until a complete image is present. All outputs except D are registered.
module td4_program_memory #(
  parameter int addrWidth = 4,
  parameter int dataWidth = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [addrWidth-1:0] A,
  output logic [dataWidth-1:0] D,
  input  logic                 LOAD_START,
  input  logic [dataWidth-1:0] LOAD_DATA,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic                 LOAD_END,
  output logic                 CPU_CLR,
  output logic                 BUSY,
  output logic [addrWidth:0]   WORD_COUNT
);

  localparam int Depth = 1 << addrWidth;
  localparam logic [addrWidth-1:0] LastAddr = addrWidth'(Depth - 1);
  localparam logic [addrWidth:0] FullCount = (addrWidth + 1)'(Depth);

  typedef enum logic [2:0] {EMPTY, LOAD, FILL, RELEASE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [dataWidth-1:0]   mem [Depth];
  logic [addrWidth-1:0]   wptr, wptr_nxt;
  logic [addrWidth:0]     count_nxt;
  logic                   we;
  logic [dataWidth-1:0]   wdata;

  assign D = mem[A];

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    count_nxt = WORD_COUNT;
    we        = 1'b0;
    wdata     = '0;
    case (state)
      EMPTY, RUN: begin
        if (LOAD_START) begin
          state_nxt = LOAD;
          wptr_nxt  = '0;
          count_nxt = '0;
        end
      end
      LOAD: begin
        // A restart wins over a byte offered in the same cycle; that byte is dropped.
        if (LOAD_START) begin
          wptr_nxt  = '0;
          count_nxt = '0;
        end else if (LOAD_VALID && LOAD_READY) begin
          we    = 1'b1;
          wdata = LOAD_DATA;
          if (WORD_COUNT != FullCount) count_nxt = WORD_COUNT + 1'b1;
          if (wptr == LastAddr) begin
            state_nxt = RELEASE;
          end else begin
            wptr_nxt = wptr + 1'b1;
            if (LOAD_END) state_nxt = FILL;
          end
        end
      end
      FILL: begin
        we = 1'b1;
        if (wptr == LastAddr) state_nxt = RELEASE;
        else wptr_nxt = wptr + 1'b1;
      end
      RELEASE: state_nxt = RUN;
      default: state_nxt = EMPTY;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state      <= EMPTY;
      wptr       <= '0;
      WORD_COUNT <= '0;
      LOAD_READY <= 1'b0;
      CPU_CLR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      WORD_COUNT <= count_nxt;
      LOAD_READY <= (state_nxt == LOAD);
      CPU_CLR    <= (state_nxt == RUN);
      BUSY       <= (state_nxt == LOAD) || (state_nxt == FILL) || (state_nxt == RELEASE);
    end
  end

  // Contents survive CLR; a reset only stops further writes.
  always_ff @(posedge CLK) begin
    if (CLR && we) mem[wptr] <= wdata;
  end

endmodule
